lane_vrf_write_arbiter: RTL

//  Downstream consumer of the per-slot stage-3 VRF write queues inside a lane.

---
 rtl/lane_vrf_write_arbiter_if.sv | 39 +++
 rtl/lane_vrf_write_arbiter.sv | 87 ++++++++
 2 files changed

// File: rtl/lane_vrf_write_arbiter_if.sv
// lane_vrf_write_arbiter_if: requester bundle, VRF write port and instruction status of the lane write arbiter.
interface lane_vrf_write_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int VD_W    = 5,
  parameter int OFF_W   = 4,
  parameter int DATA_W  = 32,
  parameter int IDX_W   = 3
);
  localparam int MASK_W   = DATA_W / 8;
  localparam int NUM_INST = 1 << IDX_W;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*VD_W-1:0]   req_vd;
  logic [NUM_REQ*OFF_W-1:0]  req_offset;
  logic [NUM_REQ*MASK_W-1:0] req_mask;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_last;
  logic [NUM_REQ*IDX_W-1:0]  req_instructionIndex;
  logic                      vrfWrite_ready;
  logic                      vrfWrite_valid;
  logic [VD_W-1:0]           vrfWrite_bits_vd;
  logic [OFF_W-1:0]          vrfWrite_bits_offset;
  logic [MASK_W-1:0]         vrfWrite_bits_mask;
  logic [DATA_W-1:0]         vrfWrite_bits_data;
  logic                      vrfWrite_bits_last;
  logic [IDX_W-1:0]          vrfWrite_bits_instructionIndex;
  logic [NUM_INST-1:0]       instructionBusy;
  logic [NUM_INST-1:0]       instructionDone;
  modport master (
    output req_valid, req_vd, req_offset, req_mask, req_data, req_last, req_instructionIndex, vrfWrite_ready,
    input  req_ready, vrfWrite_valid, vrfWrite_bits_vd, vrfWrite_bits_offset, vrfWrite_bits_mask,
           vrfWrite_bits_data, vrfWrite_bits_last, vrfWrite_bits_instructionIndex, instructionBusy, instructionDone
  );
  modport slave (
    input  req_valid, req_vd, req_offset, req_mask, req_data, req_last, req_instructionIndex, vrfWrite_ready,
    output req_ready, vrfWrite_valid, vrfWrite_bits_vd, vrfWrite_bits_offset, vrfWrite_bits_mask,
           vrfWrite_bits_data, vrfWrite_bits_last, vrfWrite_bits_instructionIndex, instructionBusy, instructionDone
  );
endinterface

// File: rtl/lane_vrf_write_arbiter.sv
// lane_vrf_write_arbiter: round-robin merge of stage-3 VRF write requests into one registered write port, with busy/done tracking.
// Optional macro VRF_WRITE_MASK_DROP_EN: accept mask==0 requests without writing them to the VRF.
module lane_vrf_write_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int VD_W    = 5,
  parameter int OFF_W   = 4,
  parameter int DATA_W  = 32,
  parameter int IDX_W   = 3
) (
  input logic clock,
  input logic reset_n,
  lane_vrf_write_arbiter_if.slave io
);
  localparam int MASK_W   = DATA_W / 8;
  localparam int NUM_INST = 1 << IDX_W;
  localparam int PW       = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  logic [PW-1:0]       rrPtr, grantIdx;
  logic [PW:0]         cand;
  logic                found, loadEn, accept, drop;
  logic [VD_W-1:0]     selVd;
  logic [OFF_W-1:0]    selOffset;
  logic [MASK_W-1:0]   selMask;
  logic [DATA_W-1:0]   selData;
  logic                selLast;
  logic [IDX_W-1:0]    selIdx;
  logic [NUM_INST-1:0] setBusy, doneNext;
  assign loadEn = ~io.vrfWrite_valid | io.vrfWrite_ready;
  // Rotating priority search starting at rrPtr, wrapping modulo NUM_REQ.
  always_comb begin
    found    = 1'b0;
    grantIdx = '0;
    cand     = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      cand = {1'b0, rrPtr} + (PW+1)'(j);
      cand = cand >= (PW+1)'(NUM_REQ) ? cand - (PW+1)'(NUM_REQ) : cand;
      if (!found && io.req_valid[cand[PW-1:0]]) begin
        found    = 1'b1;
        grantIdx = cand[PW-1:0];
      end
    end
  end
  assign accept       = found & loadEn;
  assign io.req_ready = accept ? NUM_REQ'(1) << grantIdx : '0;
  assign selVd     = io.req_vd[grantIdx*VD_W +: VD_W];
  assign selOffset = io.req_offset[grantIdx*OFF_W +: OFF_W];
  assign selMask   = io.req_mask[grantIdx*MASK_W +: MASK_W];
  assign selData   = io.req_data[grantIdx*DATA_W +: DATA_W];
  assign selLast   = io.req_last[grantIdx];
  assign selIdx    = io.req_instructionIndex[grantIdx*IDX_W +: IDX_W];
`ifdef VRF_WRITE_MASK_DROP_EN
  assign drop = accept & ~|selMask;
`else
  assign drop = 1'b0;
`endif
  assign setBusy  = accept ? NUM_INST'(1) << selIdx : '0;
  // Completions from the draining slot and from a dropped last request can coincide.
  assign doneNext = (io.vrfWrite_valid & io.vrfWrite_ready & io.vrfWrite_bits_last
                      ? NUM_INST'(1) << io.vrfWrite_bits_instructionIndex : '0)
                  | (drop & selLast ? NUM_INST'(1) << selIdx : '0);
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      io.vrfWrite_valid                 <= 1'b0;
      io.vrfWrite_bits_vd               <= '0;
      io.vrfWrite_bits_offset           <= '0;
      io.vrfWrite_bits_mask             <= '0;
      io.vrfWrite_bits_data             <= '0;
      io.vrfWrite_bits_last             <= 1'b0;
      io.vrfWrite_bits_instructionIndex <= '0;
      rrPtr                             <= '0;
      io.instructionBusy                <= '0;
      io.instructionDone                <= '0;
    end else begin
      if (loadEn) io.vrfWrite_valid <= accept & ~drop;
      if (accept & ~drop) begin
        io.vrfWrite_bits_vd               <= selVd;
        io.vrfWrite_bits_offset           <= selOffset;
        io.vrfWrite_bits_mask             <= selMask;
        io.vrfWrite_bits_data             <= selData;
        io.vrfWrite_bits_last             <= selLast;
        io.vrfWrite_bits_instructionIndex <= selIdx;
      end
      if (accept) rrPtr <= grantIdx == PW'(NUM_REQ - 1) ? '0 : grantIdx + 1'b1;
      io.instructionBusy <= (io.instructionBusy & ~doneNext) | setBusy;
      io.instructionDone <= doneNext;
    end
  end
endmodule
